// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, ID control
// transfers and multi-cycle data-memory waits, with saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rt,
    input  logic               ex_mem_read,
    input  logic [4:0]         ex_rt,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               id_ex_write,
    output logic               ex_mem_write,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               mem_wb_flush,
    output logic [COUNT_W-1:0] stall_cycles,
    output logic [COUNT_W-1:0] flush_count,
    output logic               mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT);

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;

    logic               state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [WAIT_W-1:0]  wait_inc;
    logic [COUNT_W-1:0] stall_q, stall_d;
    logic [COUNT_W-1:0] flush_q, flush_d;
    logic               timeout_q, timeout_d;
    logic               mem_stall;
    logic               load_use;

    assign wait_inc  = wait_q + 1'b1;
    assign mem_stall = dmem_req && !dmem_ready;
    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    wait_d = '0;
                    if (mem_stall) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        state_d      = ST_MEM_WAIT;
                        wait_d       = WAIT_W'(1);
                    end else if (load_use) begin
                        // Branch resolution is deferred: it is re-evaluated after the bubble.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (branch_taken || jump) begin
                        if_id_flush = 1'b1;
                    end
                end
                default: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    // On the ready cycle the completed MEM result moves into WB.
                    mem_wb_flush = !dmem_ready;
                    if (dmem_ready) begin
                        state_d = ST_RUN;
                        wait_d  = '0;
                    end else if (wait_inc == TIMEOUT_VAL) begin
                        state_d   = ST_RUN;
                        wait_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && (stall_q != {COUNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (if_id_flush && (flush_q != {COUNT_W{1'b1}})) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a spec-level model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read, branch_taken, jump, dmem_req, dmem_ready;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          if_id_flush, id_ex_flush, mem_wb_flush;
    logic [CW-1:0] stall_cycles, flush_count;
    logic          mem_timeout;

    int total = 0;
    int bad   = 0;

    // Model state
    bit m_wait = 0;
    int m_nr = 0;
    int m_stalls = 0;
    int m_flushes = 0;
    bit m_to = 0;

    pipe_hazard_ctrl #(.COUNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .jump(jump),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
        return (n > SAT) ? SAT : n;
    endfunction

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        bit freeze, lu;
        bit e_pc, e_ifw, e_idw, e_exw, e_iff, e_idf, e_mwf;
        if (rst) begin
            m_wait = 0; m_nr = 0; m_stalls = 0; m_flushes = 0; m_to = 0;
        end else begin
            check("m_stall_cycles", int'(stall_cycles), sat(m_stalls));
            check("m_flush_count", int'(flush_count), sat(m_flushes));
            check("m_mem_timeout", int'(mem_timeout), int'(m_to));

            freeze = m_wait || (dmem_req && !dmem_ready);
            lu = ex_mem_read && ex_rt != 0 &&
                 (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
            e_pc = 1; e_ifw = 1; e_idw = 1; e_exw = 1; e_iff = 0; e_idf = 0; e_mwf = 0;
            if (freeze) begin
                e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
                e_mwf = !(m_wait && dmem_ready);
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_idf = 1;
            end else begin
                e_iff = branch_taken || jump;
            end
            check("m_pc_write", int'(pc_write), int'(e_pc));
            check("m_if_id_write", int'(if_id_write), int'(e_ifw));
            check("m_id_ex_write", int'(id_ex_write), int'(e_idw));
            check("m_ex_mem_write", int'(ex_mem_write), int'(e_exw));
            check("m_if_id_flush", int'(if_id_flush), int'(e_iff));
            check("m_id_ex_flush", int'(id_ex_flush), int'(e_idf));
            check("m_mem_wb_flush", int'(mem_wb_flush), int'(e_mwf));

            if (!e_pc) m_stalls++;
            if (e_iff) m_flushes++;
            if (!m_wait) begin
                if (dmem_req && !dmem_ready) begin
                    m_wait = 1; m_nr = 1;
                end
            end else if (dmem_ready) begin
                m_wait = 0;
            end else begin
                m_nr++;
                if (m_nr == TO) begin
                    m_to = 1; m_wait = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
        branch_taken = 0; jump = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        rst = 1; idle();
        step(); step();
        rst = 0;

        // Reset taken in MEM_WAIT with nonzero counters
        dmem_req = 1;
        #1 check("run_memstall_pc", int'(pc_write), 0);
        step(); step();
        check("pre_reset_stalls", int'(stall_cycles), 2);
        rst = 1; step(); step(); rst = 0; dmem_req = 0;
        #1;
        check("reset_pc_write", int'(pc_write), 1);
        check("reset_ex_mem_write", int'(ex_mem_write), 1);
        check("reset_stalls", int'(stall_cycles), 0);
        check("reset_timeout", int'(mem_timeout), 0);

        // Load-use on rs
        ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        #1;
        check("lu_pc_write", int'(pc_write), 0);
        check("lu_if_id_write", int'(if_id_write), 0);
        check("lu_id_ex_flush", int'(id_ex_flush), 1);
        step(); idle();
        #1;
        check("lu_cleared_pc", int'(pc_write), 1);
        check("lu_stalls", int'(stall_cycles), 1);
        // r0 never hazards
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        #1 check("lu_r0_pc", int'(pc_write), 1);
        step();
        // rt match ignored when rt is not a source
        ex_rt = 5; id_rs = 3; id_rt = 5; id_uses_rt = 0;
        #1 check("lu_rt_unused_pc", int'(pc_write), 1);
        step();
        id_uses_rt = 1;
        #1 check("lu_rt_used_pc", int'(pc_write), 0);
        step(); idle();

        // Branch suppressed by load-use, then taken
        ex_mem_read = 1; ex_rt = 7; id_rs = 7; branch_taken = 1;
        #1 check("br_lu_if_id_flush", int'(if_id_flush), 0);
        step(); ex_mem_read = 0;
        #1;
        check("br_if_id_flush", int'(if_id_flush), 1);
        check("br_pc_write", int'(pc_write), 1);
        step(); idle();
        #1;
        check("br_flush_count", int'(flush_count), 1);
        check("br_stalls", int'(stall_cycles), 3);

        // Memory wait: 3 not-ready cycles then ready
        do_reset();
        dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_pc_write", int'(pc_write), 0);
            check("mw_mem_wb_flush", int'(mem_wb_flush), 1);
            step();
        end
        dmem_ready = 1;
        #1;
        check("mw_ready_pc", int'(pc_write), 0);
        check("mw_ready_mem_wb_flush", int'(mem_wb_flush), 0);
        step(); idle();
        #1;
        check("mw_after_pc", int'(pc_write), 1);
        check("mw_stalls", int'(stall_cycles), 4);
        dmem_req = 1; dmem_ready = 1;
        #1 check("req_ready_run_pc", int'(pc_write), 1);
        step(); idle();

        // Timeout with ready held low
        do_reset();
        dmem_req = 1;
        for (int i = 0; i < 3; i++) step();
        check("to_not_yet", int'(mem_timeout), 0);
        step();
        check("to_set", int'(mem_timeout), 1);
        dmem_req = 0;
        #1 check("to_back_in_run_pc", int'(pc_write), 1);
        step(); step(); step();
        check("to_sticky", int'(mem_timeout), 1);
        do_reset();
        #1 check("to_cleared", int'(mem_timeout), 0);

        // Saturation
        ex_mem_read = 1; ex_rt = 9; id_rs = 9;
        for (int i = 0; i < 20; i++) step();
        idle(); jump = 1;
        for (int i = 0; i < 20; i++) step();
        idle();
        #1;
        check("sat_stalls", int'(stall_cycles), 15);
        check("sat_flushes", int'(flush_count), 15);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
